// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the GPIO read and write channel slaves.
package axi_lite_pkg;

    localparam int unsigned REG_AW  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RESP_W  = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } rd_state_t;

    // Map a register-block error flag onto an AXI response code.
    function automatic logic [RESP_W-1:0] resp_from_err(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axrdch.sv
// AXI4-Lite read-channel slave: one outstanding read, single-cycle strobe to
// the register block, fixed-latency data capture, held read response.
module axrdch
    import axi_lite_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                iCLK,
    input  logic                iRSTN,
    input  logic [31:0]         iARADDR,
    input  logic                iARVALID,
    output logic                oARREADY,
    output logic [31:0]         oRDATA,
    output logic [1:0]          oRRESP,
    output logic                oRVALID,
    input  logic                iRREADY,
    output logic [7:0]          oPRADR,
    output logic                oPREAD,
    input  logic [31:0]         iPRDAT,
    input  logic                iPERR,
    output logic                oRDBUSY
);

    localparam int unsigned CNT_W = 4;

    rd_state_t           state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [REG_AW-1:0]   pradr_q,   pradr_d;
    logic                pread_q,   pread_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic [RESP_W-1:0]   rresp_q,   rresp_d;
    logic                rvalid_q,  rvalid_d;
    logic                arready_q, arready_d;
    logic                busy_q,    busy_d;

    // Upper address bits carry no meaning for this peripheral.
    logic unused_araddr_hi;
    assign unused_araddr_hi = ^iARADDR[31:REG_AW];

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pradr_d  = '0;
        pread_d  = 1'b0;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = rvalid_q;

        case (state_q)
            IDLE: begin
                if (iARVALID) begin
                    if (iARADDR[1:0] == 2'b00) begin
                        state_d = REQ;
                        pread_d = 1'b1;
                        pradr_d = iARADDR[REG_AW-1:0];
                    end else begin
                        // Misaligned: answer directly, register block untouched.
                        state_d  = RESP;
                        rdata_d  = '0;
                        rresp_d  = RESP_SLVERR;
                        rvalid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_d   = CNT_W'(RD_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                // <= 1 also covers an out-of-range zero latency.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    rdata_d  = iPRDAT;
                    rresp_d  = resp_from_err(iPERR);
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (iRREADY) begin
                    rvalid_d = 1'b0;
                    rdata_d  = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        arready_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers; reset drops any pending response.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pradr_q   <= '0;
            pread_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pradr_q   <= pradr_d;
            pread_q   <= pread_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
            busy_q    <= busy_d;
        end
    end

    assign oARREADY = arready_q;
    assign oRDATA   = rdata_q;
    assign oRRESP   = rresp_q;
    assign oRVALID  = rvalid_q;
    assign oPRADR   = pradr_q;
    assign oPREAD   = pread_q;
    assign oRDBUSY  = busy_q;

endmodule

// File: tb/tb_axrdch.sv
// Scoreboard bench for axrdch: instance 0 uses RD_LAT=1, instance 1 RD_LAT=4.
module tb_axrdch;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [7:0]  pradr   [2];
    logic        pread   [2];
    logic [31:0] prdat   [2];
    logic        perr    [2];
    logic        rdbusy  [2];

    int checks = 0;
    int errors = 0;

    logic [33:0] sb0[$];
    logic [33:0] sb1[$];

    axrdch #(.RD_LAT(1)) u_dut0 (
        .iCLK(clk), .iRSTN(rstn),
        .iARADDR(araddr[0]), .iARVALID(arvalid[0]), .oARREADY(arready[0]),
        .oRDATA(rdata[0]), .oRRESP(rresp[0]), .oRVALID(rvalid[0]), .iRREADY(rready[0]),
        .oPRADR(pradr[0]), .oPREAD(pread[0]), .iPRDAT(prdat[0]), .iPERR(perr[0]),
        .oRDBUSY(rdbusy[0])
    );

    axrdch #(.RD_LAT(4)) u_dut1 (
        .iCLK(clk), .iRSTN(rstn),
        .iARADDR(araddr[1]), .iARVALID(arvalid[1]), .oARREADY(arready[1]),
        .oRDATA(rdata[1]), .oRRESP(rresp[1]), .oRVALID(rvalid[1]), .iRREADY(rready[1]),
        .oPRADR(pradr[1]), .oPREAD(pread[1]), .iPRDAT(prdat[1]), .iPERR(perr[1]),
        .oRDBUSY(rdbusy[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int i, input logic [33:0] e);
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Pop and compare every accepted response.
    always @(negedge clk) begin
        if (rstn && rvalid[0] && rready[0]) begin
            if (sb0.size() == 0) check("sb0_underflow", 64'(sb0.size()), 64'd1);
            else check("sb0_resp", 64'({rresp[0], rdata[0]}), 64'(sb0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rstn && rvalid[1] && rready[1]) begin
            if (sb1.size() == 0) check("sb1_underflow", 64'(sb1.size()), 64'd1);
            else check("sb1_resp", 64'({rresp[1], rdata[1]}), 64'(sb1.pop_front()));
        end
    end

    task automatic check_idle(input int i, input string pfx);
        check({pfx, "_arready"}, 64'(arready[i]), 64'd1);
        check({pfx, "_rvalid"},  64'(rvalid[i]),  64'd0);
        check({pfx, "_rdata"},   64'(rdata[i]),   64'd0);
        check({pfx, "_pread"},   64'(pread[i]),   64'd0);
        check({pfx, "_pradr"},   64'(pradr[i]),   64'd0);
        check({pfx, "_rdbusy"},  64'(rdbusy[i]),  64'd0);
    endtask

    // Handshake in the current cycle, follow the read up to the first RVALID cycle.
    task automatic do_read(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic e, input int lat);
        logic aligned;
        aligned    = (a[1:0] == 2'b00);
        araddr[i]  = a;
        arvalid[i] = 1'b1;
        prdat[i]   = d;
        perr[i]    = 1'b0;
        check("ar_ready", 64'(arready[i]), 64'd1);
        if (aligned) push_exp(i, {(e ? RESP_SLVERR : RESP_OKAY), d});
        else         push_exp(i, {RESP_SLVERR, 32'h0});
        step();
        arvalid[i] = 1'b0;
        if (aligned) begin
            check("pread_t1", 64'(pread[i]), 64'd1);
            check("pradr_t1", 64'(pradr[i]), 64'(a[7:0]));
            check("rvalid_t1", 64'(rvalid[i]), 64'd0);
            for (int c = 0; c < lat; c++) begin
                step();
                if (c == lat - 1) perr[i] = e;
                check("rvalid_wait", 64'(rvalid[i]), 64'd0);
                check("pread_wait",  64'(pread[i]),  64'd0);
                check("busy_wait",   64'(rdbusy[i]), 64'd1);
            end
            step();
            perr[i] = 1'b0;
        end
        check("rvalid_on",  64'(rvalid[i]),  64'd1);
        check("pread_resp", 64'(pread[i]),   64'd0);
        check("pradr_resp", 64'(pradr[i]),   64'd0);
        check("ar_busy",    64'(arready[i]), 64'd0);
    endtask

    // Hold RREADY low for some cycles, then accept.
    task automatic finish_resp(input int i, input int hold, input logic pulse,
                               input logic [31:0] d, input logic [1:0] r);
        rready[i] = 1'b0;
        for (int h = 0; h < hold; h++) begin
            perr[i] = pulse && (h == 1);
            step();
            check("hold_rvalid",  64'(rvalid[i]),  64'd1);
            check("hold_rdata",   64'(rdata[i]),   64'(d));
            check("hold_rresp",   64'(rresp[i]),   64'(r));
            check("hold_arready", 64'(arready[i]), 64'd0);
        end
        perr[i]   = 1'b0;
        rready[i] = 1'b1;
        step();
        rready[i] = 1'b0;
        check_idle(i, "post_resp");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
            prdat[i] = '0;  perr[i] = 1'b0;
        end
        #12;
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        check("rst0_rresp", 64'(rresp[0]), 64'(RESP_OKAY));
        rstn = 1'b1;
        step();

        // Aligned read, then a held response with an error pulse during RESP.
        do_read(0, 32'hFFFF_FF04, 32'hDEAD_BEEF, 1'b0, 1);
        finish_resp(0, 5, 1'b1, 32'hDEAD_BEEF, RESP_OKAY);

        // Misaligned read.
        do_read(0, 32'h0000_0006, 32'h5555_AAAA, 1'b0, 1);
        finish_resp(0, 1, 1'b0, 32'h0, RESP_SLVERR);

        // Register-block error in the capture cycle.
        do_read(0, 32'h0000_000C, 32'h1234_5678, 1'b1, 1);
        finish_resp(0, 3, 1'b1, 32'h1234_5678, RESP_SLVERR);

        // Back-to-back on the RD_LAT=4 instance with RREADY tied high.
        rready[1]  = 1'b1;
        araddr[1]  = 32'h0;
        arvalid[1] = 1'b1;
        prdat[1]   = 32'hA0A0_0001;
        check("b2b_arready1", 64'(arready[1]), 64'd1);
        push_exp(1, {RESP_OKAY, 32'hA0A0_0001});
        step();
        araddr[1] = 32'h8;
        check("b2b_pread1", 64'(pread[1]), 64'd1);
        check("b2b_pradr1", 64'(pradr[1]), 64'h0);
        cyc = 1;
        while (!rvalid[1] && cyc < 20) begin
            check("b2b_noready", 64'(arready[1]), 64'd0);
            step();
            cyc++;
        end
        check("b2b_lat1", 64'(cyc), 64'd6);
        prdat[1] = 32'hB0B0_0002;
        push_exp(1, {RESP_OKAY, 32'hB0B0_0002});
        step();
        check("b2b_arready2", 64'(arready[1]), 64'd1);
        check("b2b_rvalid_off", 64'(rvalid[1]), 64'd0);
        step();
        arvalid[1] = 1'b0;
        check("b2b_pread2", 64'(pread[1]), 64'd1);
        check("b2b_pradr2", 64'(pradr[1]), 64'h8);
        cyc = 1;
        while (!rvalid[1] && cyc < 20) begin
            step();
            cyc++;
        end
        check("b2b_lat2", 64'(cyc), 64'd6);
        check("b2b_rdata2", 64'(rdata[1]), 64'hB0B0_0002);
        step();
        rready[1] = 1'b0;
        check_idle(1, "b2b_end");

        // Asynchronous reset during WAIT drops the pending read.
        do_read(1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 4);
        finish_resp(1, 0, 1'b0, 32'hCAFE_F00D, RESP_OKAY);
        araddr[1]  = 32'h14;
        arvalid[1] = 1'b1;
        prdat[1]   = 32'h7777_1111;
        step();
        arvalid[1] = 1'b0;
        step();
        step();
        check("pre_rst_busy", 64'(rdbusy[1]), 64'd1);
        rstn = 1'b0;
        #1;
        check_idle(1, "midrst");
        check("midrst_rresp", 64'(rresp[1]), 64'(RESP_OKAY));
        #2;
        rstn = 1'b1;
        step();

        do_read(1, 32'h0000_0024, 32'h0F0F_F0F0, 1'b0, 4);
        finish_resp(1, 2, 1'b0, 32'h0F0F_F0F0, RESP_OKAY);
        do_read(0, 32'h0000_00FC, 32'h8765_4321, 1'b0, 1);
        finish_resp(0, 0, 1'b0, 32'h8765_4321, RESP_OKAY);

        step();
        check("sb0_drained", 64'(sb0.size()), 64'd0);
        check("sb1_drained", 64'(sb1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axrdch.md
# axrdch

AXI4-Lite read-channel slave for the GPIO peripheral: accepts one read address at a time and issues a single-cycle read strobe to the register block. It captures the returned data and status after a fixed latency and holds the read response until the master accepts it. It is the read-direction counterpart of the write-channel slave, and both share the same register block and `iPERR` status line.

## Interface
Parameters:
- `RD_LAT`, 1: cycles from `oPREAD` assertion to valid `iPRDAT`/`iPERR`; legal range 1..15.

Ports:
- `iCLK`  in  1  clock
- `iRSTN`  in  1  reset, asynchronous, active-low
- `iARADDR`  in  32  AXI read address; bits [7:0] used, [31:8] ignored
- `iARVALID`  in  1  AXI read address valid
- `oARREADY`  out  1  AXI read address ready
- `oRDATA`  out  32  AXI read data
- `oRRESP`  out  2  AXI read response: OKAY=2'b00, SLVERR=2'b10
- `oRVALID`  out  1  AXI read data valid
- `iRREADY`  in  1  AXI read data ready
- `oPRADR`  out  8  register-block read address
- `oPREAD`  out  1  register-block read strobe, one cycle
- `iPRDAT`  in  32  register-block read data
- `iPERR`  in  1  register-block error, sampled with `iPRDAT`
- `oRDBUSY`  out  1  read transaction in progress (state != IDLE)

## Operation
- FSM states and transitions:
  - IDLE: on `iARVALID` → capture `iARADDR[7:0]`. If `iARADDR[1:0]==0` go to REQ, else go to RESP with SLVERR and data 0.
  - REQ: one cycle. Drive `oPREAD=1` and `oPRADR` = captured address. Load latency counter with `RD_LAT`, then go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, register `iPRDAT` into the data register and `iPERR` into the response register (OKAY or SLVERR), then go to RESP.
  - RESP: `oRVALID=1`. `oRDATA` and `oRRESP` are held stable. When `iRREADY` is high, return to IDLE.
- `oARREADY` = (state == IDLE). Only one transaction is outstanding at a time; no address buffering.
- `oPRADR` is 0 and `oPREAD` is 0 in every state except REQ.
- `oRDATA` is cleared to 0 on return to IDLE.
- `iARADDR[31:8]` is ignored, and `ARPROT` is not present.
- The write channel drops its ready signal while `iARVALID` is high, so reads take priority at the slave. This block has no write-side input.

## Timing
- Reset values while `iRSTN` is low: state IDLE, `oARREADY=1`, `oRVALID=0`, `oRDATA=0`, `oRRESP=OKAY`, `oPREAD=0`, `oPRADR=0`, `oRDBUSY=0`.
- Aligned read, with the address handshake in cycle T:
  - `oPREAD` high in cycle T+1.
  - Data sampled at the end of cycle T+1+`RD_LAT`.
  - `oRVALID` high from cycle T+2+`RD_LAT`. With `RD_LAT=1`, `oRVALID` rises at T+3.
- Misaligned read, with the handshake in cycle T: `oRVALID` high at T+1; no `oPREAD` is issued.
- If `iRREADY` is high in the first `oRVALID` cycle R: `oRVALID` low and `oARREADY` high at R+1. A new handshake can occur at R+1.
- `iRREADY` held low: the response stays unchanged indefinitely.
- `iARVALID` during REQ/WAIT/RESP is ignored (`oARREADY=0`). The master must keep it asserted until the next IDLE.
- `iPERR` is sampled only in the capture cycle; `iPERR` pulses outside that cycle have no effect.
- An asynchronous reset mid-transaction returns all outputs to their reset values immediately. The pending response is discarded.

## Structure
- Shared package `axi_lite_pkg` holds:
  - `RESP_OKAY` and `RESP_SLVERR` constants, which the write channel also uses.
  - The `rd_state_t` enum {IDLE, REQ, WAIT, RESP}.
  - The register address width constant (8).
- Single module, no sub-module. The latency counter is 4 bits and stays inline.

## Test plan
- Reset, `RD_LAT=1`: `iARADDR=0x04`, `iPRDAT=0xDEADBEEF` → `oPREAD` at T+1 with `oPRADR=0x04`; `oRVALID` at T+3 with `oRDATA=0xDEADBEEF` and `oRRESP=00`.
- `iRREADY` held low for 5 cycles after `oRVALID` → data and response stable and `oARREADY=0` throughout. `iRREADY=1` → `oRVALID` low and `oARREADY` high the next cycle.
- `iARADDR=0x06` (misaligned) → no `oPREAD`; `oRVALID` at T+1 with `oRRESP=10` and `oRDATA=0`.
- `iPERR=1` in the capture cycle, with `iPRDAT=0x12345678` → `oRRESP=10` and `oRDATA=0x12345678`. An `iPERR` pulse during RESP leaves `oRRESP` unchanged.
- `RD_LAT=4`, back-to-back reads of 0x00 and 0x08 with `iRREADY` tied high → `oRVALID` at T+6; second handshake the cycle after the first response completes; correct data on each.
- `iRSTN` dropped during WAIT → `oRVALID`, `oPREAD`, `oRDATA` and `oRDBUSY` go to 0 and `oARREADY` goes to 1 immediately. After release, a normal read completes.
